// File: rtl/discr_scaler_counter.sv
// Discriminator scaler counter: sums accepted edges over contiguous gate windows
// and hands each window total to the readout side through a valid/ack handshake.
`timescale 1ns/1ps
module discr_scaler_counter #(
    parameter int CNT_W = 24,
    parameter int ID_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [7:0]       bits_in,
    input  logic [31:0]      gate_len,
    output logic [CNT_W-1:0] count_out,
    output logic [ID_W-1:0]  count_id,
    output logic             count_sat,
    output logic             count_valid,
    input  logic             count_ack,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] acc_q;
    logic             sat_q;
    logic [31:0]      gate_cnt_q;
    logic [31:0]      len_q;
    logic [ID_W-1:0]  idx_q;
    logic [CNT_W-1:0] count_out_q;
    logic [ID_W-1:0]  count_id_q;
    logic             count_sat_q;
    logic             count_valid_q;
    logic             overrun_q;
    logic             busy_q;

    logic [3:0]       pop;
    logic [CNT_W:0]   sum_wide;
    logic             clamp;
    logic [CNT_W-1:0] acc_d;
    logic             sat_d;
    logic [31:0]      len_d;
    logic             window_end;

    always_comb begin
        pop = '0;
        for (int i = 0; i < 8; i++) begin
            pop = pop + 4'(bits_in[i]);
        end
    end

    // One extra bit of headroom lets the carry out signal a clamp directly.
    assign sum_wide   = {1'b0, acc_q} + (CNT_W+1)'(pop);
    assign clamp      = sum_wide[CNT_W];
    assign acc_d      = clamp ? {CNT_W{1'b1}} : sum_wide[CNT_W-1:0];
    assign sat_d      = sat_q | clamp;
    assign len_d      = (gate_len == 32'd0) ? 32'd1 : gate_len;
    assign window_end = (gate_cnt_q == len_q - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            sat_q         <= 1'b0;
            gate_cnt_q    <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            count_out_q   <= '0;
            count_id_q    <= '0;
            count_sat_q   <= 1'b0;
            count_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            if (count_valid_q && count_ack) begin
                count_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    acc_q      <= '0;
                    sat_q      <= 1'b0;
                    gate_cnt_q <= '0;
                    idx_q      <= '0;
                    overrun_q  <= 1'b0;
                    if (en) begin
                        state_q <= COUNT;
                        len_q   <= len_d;
                        busy_q  <= 1'b1;
                    end
                end
                COUNT: begin
                    if (!en) begin
                        // Abort drops the partial window but leaves any pending result alone.
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        acc_q      <= '0;
                        sat_q      <= 1'b0;
                        gate_cnt_q <= '0;
                        idx_q      <= '0;
                    end else if (window_end) begin
                        count_out_q   <= acc_d;
                        count_sat_q   <= sat_d;
                        count_id_q    <= idx_q;
                        count_valid_q <= 1'b1;
                        if (count_valid_q && !count_ack) begin
                            overrun_q <= 1'b1;
                        end
                        idx_q      <= idx_q + ID_W'(1);
                        acc_q      <= '0;
                        sat_q      <= 1'b0;
                        gate_cnt_q <= '0;
                        len_q      <= len_d;
                    end else begin
                        acc_q      <= acc_d;
                        sat_q      <= sat_d;
                        gate_cnt_q <= gate_cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign count_out   = count_out_q;
    assign count_id    = count_id_q;
    assign count_sat   = count_sat_q;
    assign count_valid = count_valid_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_discr_scaler_counter.sv
// Bench for discr_scaler_counter: a wide and a narrow (saturating) instance share
// stimulus; a window-sum reference model feeds a scoreboard drained by a monitor.
`timescale 1ns/1ps
module tb_discr_scaler_counter;

    localparam longint MAX24 = 64'd16777215;
    localparam longint MAX4  = 64'd15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        count_ack = 1'b0;
    logic [7:0]  bits_in = 8'h00;
    logic [31:0] gate_len = 32'd0;

    logic [23:0] count_out;
    logic [15:0] count_id;
    logic        count_sat, count_valid, overrun, busy;
    logic [3:0]  s_count_out;
    logic [15:0] s_count_id;
    logic        s_count_sat, s_count_valid, s_overrun, s_busy;

    always #5 clk = ~clk;

    discr_scaler_counter #(.CNT_W(24), .ID_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .bits_in(bits_in), .gate_len(gate_len),
        .count_out(count_out), .count_id(count_id), .count_sat(count_sat),
        .count_valid(count_valid), .count_ack(count_ack), .overrun(overrun), .busy(busy)
    );

    discr_scaler_counter #(.CNT_W(4), .ID_W(16)) dutSat (
        .clk(clk), .rst_n(rst_n), .en(en), .bits_in(bits_in), .gate_len(gate_len),
        .count_out(s_count_out), .count_id(s_count_id), .count_sat(s_count_sat),
        .count_valid(s_count_valid), .count_ack(count_ack), .overrun(s_overrun), .busy(s_busy)
    );

    typedef struct {
        longint cnt24;
        bit     sat24;
        longint cnt4;
        bit     sat4;
        longint id;
        bit     ovr;
    } exp_t;

    exp_t   sbq[$];
    int     total = 0;
    int     bad = 0;

    bit     mRun, mValid, mOvr;
    int     mPos, mLen, mId;
    longint mSum;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Window-level reference: sum popcounts over the window, clamp only when reporting.
    task automatic modelEdge(input bit e, input logic [7:0] b, input logic [31:0] len, input bit a);
        exp_t x;
        int   nl;
        bit   ackTaken;
        nl = (len == 32'd0) ? 1 : int'(len);
        ackTaken = a && mValid;
        if (!mRun) begin
            mOvr = 1'b0;
            mId = 0;
            if (ackTaken) mValid = 1'b0;
            if (e) begin
                mRun = 1'b1; mPos = 0; mSum = 0; mLen = nl;
            end
        end else if (!e) begin
            mRun = 1'b0;
            mId = 0;
            if (ackTaken) mValid = 1'b0;
        end else begin
            mSum += $countones(b);
            if (mPos == mLen - 1) begin
                x.cnt24 = (mSum > MAX24) ? MAX24 : mSum;
                x.sat24 = (mSum > MAX24);
                x.cnt4  = (mSum > MAX4) ? MAX4 : mSum;
                x.sat4  = (mSum > MAX4);
                x.id    = mId;
                x.ovr   = mOvr || (mValid && !a);
                sbq.push_back(x);
                mOvr = x.ovr;
                mValid = 1'b1;
                mId = (mId + 1) % 65536;
                mSum = 0; mPos = 0; mLen = nl;
            end else begin
                mPos++;
                if (ackTaken) mValid = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input bit e, input logic [7:0] b, input logic [31:0] len, input bit a);
        en = e;
        bits_in = b;
        gate_len = len;
        count_ack = a;
        modelEdge(e, b, len, a);
        @(posedge clk);
        #1;
    endtask

    // Pulls reset between clock edges and expects every output to drop at once.
    task automatic asyncReset();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_count_out", longint'(count_out), 0);
        checkOutput("rst_count_id", longint'(count_id), 0);
        checkOutput("rst_count_valid", longint'(count_valid), 0);
        checkOutput("rst_overrun", longint'(overrun), 0);
        checkOutput("rst_busy", longint'(busy), 0);
        checkOutput("rst_s_busy", longint'(s_busy), 0);
        mRun = 1'b0; mValid = 1'b0; mOvr = 1'b0; mId = 0;
        sbq.delete();
        @(posedge clk);
        #1;
        en = 1'b0;
        rst_n = 1'b1;
    endtask

    // A new presentation is a rising valid or a changed index while valid stays up.
    logic        prevValid = 1'b0;
    logic [15:0] prevId = 16'd0;
    exp_t        mx;
    always @(negedge clk) begin
        if (rst_n && count_valid && (!prevValid || count_id != prevId)) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_result: got id %0d count %0d, expected none", count_id, count_out);
            end else begin
                mx = sbq.pop_front();
                checkOutput("count_out", longint'(count_out), mx.cnt24);
                checkOutput("count_sat", longint'(count_sat), longint'(mx.sat24));
                checkOutput("count_id", longint'(count_id), mx.id);
                checkOutput("overrun", longint'(overrun), longint'(mx.ovr));
                checkOutput("s_count_out", longint'(s_count_out), mx.cnt4);
                checkOutput("s_count_sat", longint'(s_count_sat), longint'(mx.sat4));
                checkOutput("s_count_id", longint'(s_count_id), mx.id);
                checkOutput("s_count_valid", longint'(s_count_valid), 1);
                checkOutput("s_overrun", longint'(s_overrun), longint'(mx.ovr));
            end
        end
        prevValid = count_valid;
        prevId = count_id;
    end

    logic       re, ra;
    logic [7:0] rb;
    logic [31:0] rl;

    initial begin
        mRun = 1'b0; mValid = 1'b0; mOvr = 1'b0; mPos = 0; mLen = 1; mId = 0; mSum = 0;
        #1;
        checkOutput("init_count_valid", longint'(count_valid), 0);
        checkOutput("init_busy", longint'(busy), 0);
        checkOutput("init_count_out", longint'(count_out), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic count: 1+2+0+8 edges in a 4-cycle window.
        applyStimulus(0, 8'h00, 4, 0);
        applyStimulus(1, 8'h00, 4, 0);
        applyStimulus(1, 8'h01, 4, 0);
        applyStimulus(1, 8'h03, 4, 0);
        applyStimulus(1, 8'h00, 4, 0);
        applyStimulus(1, 8'hFF, 4, 0);
        checkOutput("t1_valid", longint'(count_valid), 1);
        checkOutput("t1_out", longint'(count_out), 11);
        checkOutput("t1_busy", longint'(busy), 1);
        applyStimulus(1, 8'h00, 4, 1);
        checkOutput("t1_valid_after_ack", longint'(count_valid), 0);
        applyStimulus(0, 8'h00, 4, 1);
        applyStimulus(0, 8'h00, 4, 1);

        // Back-to-back 2-cycle windows of constant 0xAA.
        applyStimulus(1, 8'h00, 2, 1);
        for (int i = 0; i < 12; i++) applyStimulus(1, 8'hAA, 2, 1);
        checkOutput("t2_overrun", longint'(overrun), 0);
        applyStimulus(0, 8'h00, 2, 1);
        applyStimulus(0, 8'h00, 2, 1);

        // gate_len 0 behaves as 1: one result per cycle.
        applyStimulus(1, 8'h00, 0, 1);
        for (int i = 0; i < 8; i++) applyStimulus(1, 8'h10, 0, 1);
        checkOutput("t3_valid", longint'(count_valid), 1);
        checkOutput("t3_overrun", longint'(overrun), 0);
        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(0, 8'h00, 0, 1);

        // Overrun, then ack coinciding with a new result, then clear by idling.
        applyStimulus(1, 8'h00, 3, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1, 8'h05, 3, 0);
        checkOutput("t4_overrun_set", longint'(overrun), 1);
        checkOutput("t4_id", longint'(count_id), 1);
        applyStimulus(1, 8'h01, 3, 0);
        applyStimulus(1, 8'h01, 3, 0);
        applyStimulus(1, 8'h01, 3, 1);
        checkOutput("t4_valid_on_ack", longint'(count_valid), 1);
        checkOutput("t4_overrun_kept", longint'(overrun), 1);
        applyStimulus(0, 8'h00, 3, 0);
        applyStimulus(0, 8'h00, 3, 0);
        checkOutput("t4_overrun_clear", longint'(overrun), 0);
        checkOutput("t4_held_valid", longint'(count_valid), 1);
        checkOutput("t4_held_id", longint'(count_id), 2);
        applyStimulus(0, 8'h00, 3, 1);
        checkOutput("t4_valid_cleared", longint'(count_valid), 0);

        // Saturation on the narrow instance, then recovery.
        applyStimulus(1, 8'h00, 3, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'hFF, 3, 0);
        checkOutput("t5_s_out", longint'(s_count_out), 15);
        checkOutput("t5_s_sat", longint'(s_count_sat), 1);
        checkOutput("t5_out", longint'(count_out), 24);
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'h01, 3, i == 2);
        checkOutput("t5_s_out_next", longint'(s_count_out), 3);
        checkOutput("t5_s_sat_next", longint'(s_count_sat), 0);
        applyStimulus(0, 8'h00, 3, 1);
        applyStimulus(0, 8'h00, 3, 1);

        // Abort mid-window keeps the pending result; async reset wipes everything.
        applyStimulus(1, 8'h00, 5, 0);
        for (int i = 0; i < 7; i++) applyStimulus(1, 8'hFF, 5, 0);
        applyStimulus(0, 8'hFF, 5, 0);
        checkOutput("t6_busy", longint'(busy), 0);
        checkOutput("t6_s_busy", longint'(s_busy), 0);
        applyStimulus(0, 8'h00, 5, 0);
        checkOutput("t6_held_valid", longint'(count_valid), 1);
        checkOutput("t6_held_out", longint'(count_out), 40);
        checkOutput("t6_held_id", longint'(count_id), 0);
        applyStimulus(0, 8'h00, 5, 1);
        applyStimulus(1, 8'h00, 5, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'h03, 5, 0);
        asyncReset();
        applyStimulus(1, 8'h00, 2, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'h01, 2, 1);
        applyStimulus(0, 8'h00, 2, 1);
        applyStimulus(0, 8'h00, 2, 1);

        // Randomized traffic; ack is forced whenever en drops so presentations stay distinguishable.
        for (int i = 0; i < 400; i++) begin
            re = ($urandom_range(0, 19) != 0);
            ra = re ? 1'($urandom_range(0, 1)) : 1'b1;
            rb = 8'($urandom);
            rl = 32'($urandom_range(0, 4));
            applyStimulus(re, rb, rl, ra);
        end

        applyStimulus(0, 8'h00, 1, 1);
        applyStimulus(0, 8'h00, 1, 1);
        applyStimulus(0, 8'h00, 1, 1);
        checkOutput("scoreboard_drained", longint'(sbq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
